// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Decodes PS/2 Set-2 scan-code byte sequences (E0 extended, F0 break,
//   E1 pause) into key events, filters keyboard status bytes, and queues
//   events in a first-word fall-through FIFO with a valid/ready interface.
//   A watchdog returns the decoder to IDLE if a multi-byte sequence stalls.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_byte         received scan-code byte
//   i_byte_valid   one-cycle strobe qualifying i_byte
//   i_evt_ready    consumer accepts the head event
//   o_evt_valid    FIFO not empty
//   o_evt_code     head event scan code
//   o_evt_ext      head event came from an E0/E1 sequence
//   o_evt_release  head event is a break (key up)
//   o_count        FIFO occupancy
//   o_overflow     sticky: an event was dropped on a full FIFO
//   o_timeout      one-cycle pulse when the watchdog aborts a sequence
//   o_busy         decoder is inside a prefix sequence
module ps2_scan_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_byte,
    input  logic                     i_byte_valid,
    input  logic                     i_evt_ready,
    output logic                     o_evt_valid,
    output logic [7:0]               o_evt_code,
    output logic                     o_evt_ext,
    output logic                     o_evt_release,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_timeout,
    output logic                     o_busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [WW-1:0]   wd_q;
    logic            timeout_q;
    logic            overflow_q;
    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_q;

    logic            push, push_ok, pop, full, fire;
    logic [9:0]      push_data;

    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFD) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        push      = 1'b0;
        push_data = {2'b00, i_byte};
        fire      = 1'b0;
        if (i_byte_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (i_byte == 8'hE0) begin
                        state_d = EXT;
                    end else if (i_byte == 8'hF0) begin
                        state_d = BRK;
                    end else if (i_byte == 8'hE1) begin
                        state_d = PAUSE;
                        skip_d  = 3'd7;
                    end else if (!is_status(i_byte)) begin
                        push = 1'b1;
                    end
                end
                EXT: begin
                    if (i_byte == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d   = IDLE;
                        push      = !is_fake_shift(i_byte);
                        push_data = {2'b10, i_byte};
                    end
                end
                BRK: begin
                    state_d   = IDLE;
                    push      = 1'b1;
                    push_data = {2'b01, i_byte};
                end
                EXT_BRK: begin
                    state_d   = IDLE;
                    push      = !is_fake_shift(i_byte);
                    push_data = {2'b11, i_byte};
                end
                PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d   = IDLE;
                        push      = 1'b1;
                        push_data = {2'b10, 8'hE1};
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && wd_q == WD_LAST) begin
            // A strobe in the expiry cycle takes the branch above instead.
            fire    = 1'b1;
            state_d = IDLE;
        end
    end

    assign pop     = (count_q != '0) && i_evt_ready;
    assign full    = (count_q == FULL_CNT);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            timeout_q <= fire;
            if (i_byte_valid || state_q == IDLE || fire) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WW'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign o_evt_valid   = (count_q != '0);
    assign o_evt_ext     = mem[rd_ptr][9];
    assign o_evt_release = mem[rd_ptr][8];
    assign o_evt_code    = mem[rd_ptr][7:0];
    assign o_count       = count_q;
    assign o_overflow    = overflow_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb_ps2_scan_sequencer
//   Drives directed and random scan-code traffic into ps2_scan_sequencer and
//   compares every cycle against a sequence-level reference model: pending
//   bytes are collected until they form a complete Set-2 sequence, and
//   events go into a bounded queue standing in for the FIFO.
module tb_ps2_scan_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_byte = '0;
    logic       i_byte_valid = 1'b0;
    logic       i_evt_ready = 1'b0;
    logic       o_evt_valid, o_evt_ext, o_evt_release, o_overflow, o_timeout, o_busy;
    logic [7:0] o_evt_code;
    logic [2:0] o_count;

    int total = 0;
    int bad = 0;

    ps2_scan_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .i_evt_ready(i_evt_ready), .o_evt_valid(o_evt_valid), .o_evt_code(o_evt_code),
        .o_evt_ext(o_evt_ext), .o_evt_release(o_evt_release), .o_count(o_count),
        .o_overflow(o_overflow), .o_timeout(o_timeout), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [9:0] fq[$];
    logic [7:0] sq[$];
    int  gap = 0;
    bit  exp_ovf = 0;
    bit  exp_to = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_status(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    // Examine the pending byte list; when it forms a complete sequence,
    // clear it and report the event (if the sequence yields one).
    function automatic void classify(output bit have, output logic [9:0] ev);
        logic [7:0] k;
        bit done;
        have = 0;
        ev = '0;
        done = 0;
        if (sq[0] == 8'hE1) begin
            if (sq.size() == 8) begin
                done = 1; have = 1; ev = {2'b10, 8'hE1};
            end
        end else if (sq[0] == 8'hE0) begin
            if (sq.size() == 2 && sq[1] != 8'hF0) begin
                k = sq[1]; done = 1; have = !(k == 8'h12 || k == 8'h59); ev = {2'b10, k};
            end else if (sq.size() == 3) begin
                k = sq[2]; done = 1; have = !(k == 8'h12 || k == 8'h59); ev = {2'b11, k};
            end
        end else if (sq[0] == 8'hF0) begin
            if (sq.size() == 2) begin
                done = 1; have = 1; ev = {2'b01, sq[1]};
            end
        end else begin
            done = 1; have = !is_status(sq[0]); ev = {2'b00, sq[0]};
        end
        if (done) sq.delete();
    endfunction

    task automatic model_edge(input bit rst, input bit v, input logic [7:0] b, input bit r);
        bit pop, have;
        logic [9:0] ev;
        have = 0;
        ev = '0;
        if (rst) begin
            fq.delete(); sq.delete(); gap = 0; exp_ovf = 0; exp_to = 0;
            return;
        end
        pop = (fq.size() != 0) && r;
        exp_to = 0;
        if (v) begin
            gap = 0;
            sq.push_back(b);
            classify(have, ev);
        end else begin
            gap++;
            if (sq.size() != 0 && gap == TMO) begin
                sq.delete();
                exp_to = 1;
            end
        end
        if (pop) void'(fq.pop_front());
        if (have) begin
            if (fq.size() < DEPTH) fq.push_back(ev);
            else exp_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check("valid", o_evt_valid, fq.size() != 0);
        check("count", o_count, fq.size());
        check("overflow", o_overflow, exp_ovf);
        check("timeout", o_timeout, exp_to);
        check("busy", o_busy, sq.size() != 0);
        if (fq.size() != 0) check("head", {o_evt_ext, o_evt_release, o_evt_code}, fq[0]);
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit r, input bit rst = 0);
        i_rst = rst; i_byte_valid = v; i_byte = b; i_evt_ready = r;
        @(posedge clk);
        model_edge(rst, v, b, r);
        #1;
        compare_all();
        i_rst = 0; i_byte_valid = 0;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 8'h00, r);
    endtask

    task automatic send(input logic [7:0] b, input int gap_cyc);
        step(1, b, 0);
        idle(gap_cyc, 0);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 9))
            0: return 8'hE0;
            1: return 8'hF0;
            2: return 8'hE1;
            3: return 8'h12;
            4: return 8'h59;
            5: return 8'hAA;
            6: return 8'hFA;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        // 1: reset, single make code, pop
        step(0, 8'h00, 0, 1);
        check("rst_code", {o_evt_ext, o_evt_release, o_evt_code}, 10'h000);
        check("rst_valid", o_evt_valid, 1'b0);
        step(1, 8'h1C, 0);
        check("t1_code", {o_evt_ext, o_evt_release, o_evt_code}, 10'h01C);
        check("t1_count", o_count, 3'd1);
        step(0, 8'h00, 1);
        check("t1_pop", o_count, 3'd0);

        // 2: break code with a gap
        send(8'hF0, 4);
        check("t2_busy", o_busy, 1'b1);
        send(8'h1C, 1);
        idle(2, 1);

        // 3: extended make/break and fake shift
        send(8'hE0, 0); send(8'h75, 0);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        send(8'hE0, 0); send(8'h12, 0);
        check("t3_count", o_count, 3'd2);
        idle(3, 1);

        // 4: pause sequence and status bytes
        foreach (sq[i]) sq.delete(i);
        begin
            logic [7:0] pz [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            foreach (pz[i]) send(pz[i], 1);
        end
        check("t4_code", {o_evt_ext, o_evt_release, o_evt_code}, 10'h2E1);
        send(8'hAA, 0); send(8'hFA, 0);
        check("t4_count", o_count, 3'd1);
        idle(2, 1);

        // 5: overflow, drain order, push while full with pop
        begin
            logic [7:0] fl [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
            foreach (fl[i]) send(fl[i], 0);
        end
        check("t5_count", o_count, 3'd4);
        check("t5_ovf", o_overflow, 1'b1);
        idle(5, 1);
        step(0, 8'h00, 0, 1);
        send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0);
        step(1, 8'h35, 1);
        check("t5_full_ovf", o_overflow, 1'b0);
        check("t5_full_cnt", o_count, 3'd4);
        idle(5, 1);

        // 6: watchdog abort, then reset mid-sequence
        send(8'hE0, TMO + 5);
        send(8'h1C, 0);
        idle(2, 1);
        send(8'hF0, 2);
        step(0, 8'h00, 0, 1);
        check("t6_rst_cnt", o_count, 3'd0);
        idle(3, 0);

        // Random traffic, dense then sparse enough to hit the watchdog
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, pick_byte(), $urandom_range(0, 1) == 1);
        for (int i = 0; i < 6000; i++)
            step($urandom_range(0, 59) == 0, pick_byte(), $urandom_range(0, 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
Sits between the PS/2 byte receiver and game/control logic. Consumes raw scan-code bytes, runs the Set-2 prefix state machine (E0 extended, F0 break, E1 pause sequence) and filters keyboard status bytes. Emits one decoded key event per complete sequence into a small FIFO with a valid/ready interface. A watchdog aborts a stalled prefix sequence.

Parameters:
DEPTH, 4, event FIFO entries; power of 2, at least 2.
TIMEOUT_CYC, 50000, i_clk cycles allowed between bytes of one sequence before abort.

Ports:
i_clk  in  1  system clock; all logic rises on this edge.
i_rst  in  1  synchronous active-high reset.
i_byte  in  8  received scan-code byte.
i_byte_valid  in  1  one-cycle strobe; i_byte is valid in that cycle.
i_evt_ready  in  1  consumer accepts the head event this cycle.
o_evt_valid  out  1  FIFO not empty.
o_evt_code  out  8  head event scan code.
o_evt_ext  out  1  head event came from an E0/E1 sequence.
o_evt_release  out  1  head event is a break (key up).
o_count  out  $clog2(DEPTH)+1  FIFO occupancy.
o_overflow  out  1  sticky; an event was dropped because the FIFO was full.
o_timeout  out  1  one-cycle pulse when the watchdog aborts a sequence.
o_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset: i_rst sampled high forces FSM=IDLE, FIFO empty, pointers 0, skip counter and watchdog 0. All outputs read 0 in the next cycle. A reset mid-sequence discards the partial sequence and emits no event.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Only bytes with i_byte_valid=1 advance the FSM.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to PAUSE and loads skip=7.
  - 00, AA, EE, FA, FC, FD, FE, FF are dropped and the FSM stays in IDLE.
  - Any other byte pushes {ext=0, rel=0, byte}.
- EXT: F0 goes to EXT_BRK. 12 or 59 (fake shift) is dropped and the FSM returns to IDLE. Any other byte pushes {1, 0, byte} and returns to IDLE.
- BRK: any byte pushes {0, 1, byte} and returns to IDLE.
- EXT_BRK: 12 or 59 is dropped and the FSM returns to IDLE. Any other byte pushes {1, 1, byte} and returns to IDLE.
- PAUSE: each byte decrements skip. On the byte that brings skip to 0, push {1, 0, E1} and return to IDLE. Byte contents are not checked.
- Latency: a byte strobed in cycle N is decided on the clock edge closing cycle N. o_evt_valid and the head fields reflect the event in cycle N+1 when the FIFO was empty.
- FIFO: first-word fall-through. Head fields are valid whenever o_evt_valid=1 and are don't-care (held) otherwise.
  - Pop happens when o_evt_valid and i_evt_ready are both 1.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - A push that is not accepted is dropped and sets o_overflow until i_rst. The FSM advances regardless.
  - Push and pop in the same cycle leaves o_count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Watchdog:
  - The counter clears on every i_byte_valid and whenever the FSM is in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 with no byte strobed that cycle, the FSM goes to IDLE and o_timeout pulses high for one cycle. No event is pushed.
  - A byte strobed in the same cycle as the timeout is processed normally and suppresses the timeout.
- o_busy = (state != IDLE), registered alongside the state.

Test Plan:
1. Reset, then strobe 1C -> in the next cycle o_evt_valid=1, code=1C, ext=0, rel=0, o_count=1. Assert i_evt_ready -> o_count=0.
2. Strobe F0 then 1C, 5 cycles apart -> exactly one event {0, 1, 1C}; o_busy=1 between the two strobes.
3. Strobe E0 75, then E0 F0 75, then E0 12 -> events {1, 0, 75} and {1, 1, 75} only; E0 12 produces no event.
4. Strobe E1 14 77 E1 F0 14 F0 77 -> a single event {1, 0, E1} after the 8th byte; AA and FA strobed in IDLE produce no event.
5. DEPTH=4, i_evt_ready=0, strobe 15 1D 24 2D 2C -> o_count=4 and o_overflow=1. Drain in order 15 1D 24 2D. With the FIFO full and i_evt_ready=1 in the same cycle, strobing 35 is accepted with no overflow.
6. TIMEOUT_CYC=100: strobe E0, then idle -> o_timeout pulses once, o_busy=0, and a later 1C yields {0, 0, 1C}. Separately, strobe F0 then assert i_rst -> no event and FIFO empty.
